// File: rtl/bxctreme_nonce_scheduler.sv
// Nonce scheduler: feeds base nonces to a fixed-latency hashing chain
// and retires them in order, catching the first victory per job.
module bxctreme_nonce_scheduler #(
  parameter  int PARTITIONBITS = 1,
  parameter  int LATENCY       = 130,
  localparam int NB            = 32 - PARTITIONBITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     job_valid_i,
  output logic                     job_ready_o,
  input  logic [7:0][31:0]         job_hashstate_i,
  input  logic [1:0][31:0]         job_words_i,
  input  logic [NB-1:0]            job_nonce_i,
  input  logic [NB-1:0]            job_count_i,
  input  logic                     abort_i,
  output logic                     valid_o,
  output logic                     newblock_o,
  output logic [7:0][31:0]         hashstate_o,
  output logic [2:0][31:0]         words_o,
  input  logic                     victory_i,
  input  logic [PARTITIONBITS-1:0] nonce_start_i,
  output logic                     result_valid_o,
  output logic                     result_found_o,
  output logic [31:0]              result_nonce_o,
  input  logic                     result_ready_i
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam logic [NB-1:0] LAT = NB'(LATENCY);

  state_e           state_q, state_d;
  logic [7:0][31:0] hs_q, hs_d;
  logic [1:0][31:0] wd_q, wd_d;
  logic [NB-1:0]    nonce_q, nonce_d;
  logic [NB-1:0]    count_q, count_d;
  logic [NB-1:0]    issued_q, issued_d;
  logic [NB-1:0]    retired_q, retired_d;
  logic [NB-1:0]    lat_q, lat_d;
  logic             found_q, found_d;
  logic             abort_seen_q, abort_seen_d;
  logic [31:0]      res_q, res_d;

  logic             retiring;
  logic             abort_now;
  logic             vic_acc;
  logic             issue;
  logic [NB-1:0]    issue_nonce;
  logic [NB-1:0]    ret_nonce;

  assign issue_nonce = nonce_q + issued_q;
  assign ret_nonce   = nonce_q + retired_q;
  assign retiring    = (lat_q == LAT) && (retired_q < issued_q);
  assign abort_now   = abort_i && (state_q == RUN || state_q == DRAIN);
  assign vic_acc     = victory_i && retiring && !found_q
                       && !abort_seen_q && !abort_now;
  assign issue       = (state_q == RUN) && !abort_i && !vic_acc;

  always_comb begin
    state_d      = state_q;
    hs_d         = hs_q;
    wd_d         = wd_q;
    nonce_d      = nonce_q;
    count_d      = count_q;
    issued_d     = issued_q;
    retired_d    = retired_q;
    lat_d        = lat_q;
    found_d      = found_q;
    abort_seen_d = abort_seen_q;
    res_d        = res_q;

    if (issue) issued_d = issued_q + 1'b1;
    if (retiring) retired_d = retired_q + 1'b1;
    // Latency clock runs from the first issue and then saturates.
    if (lat_q != LAT && (issue || issued_q != '0))
      lat_d = lat_q + 1'b1;
    if (abort_now) abort_seen_d = 1'b1;
    if (vic_acc) begin
      found_d = 1'b1;
      res_d   = {nonce_start_i, ret_nonce};
    end

    unique case (state_q)
      IDLE: begin
        if (job_valid_i) begin
          hs_d         = job_hashstate_i;
          wd_d         = job_words_i;
          nonce_d      = job_nonce_i;
          count_d      = job_count_i;
          issued_d     = '0;
          retired_d    = '0;
          lat_d        = '0;
          found_d      = 1'b0;
          abort_seen_d = 1'b0;
          res_d        = '0;
          state_d      = (job_count_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort_i || vic_acc || (issued_q + 1'b1 == count_q))
          state_d = DRAIN;
      end
      DRAIN: begin
        if (retired_d == issued_q) state_d = DONE;
      end
      DONE: begin
        if (result_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      hs_q         <= '0;
      wd_q         <= '0;
      nonce_q      <= '0;
      count_q      <= '0;
      issued_q     <= '0;
      retired_q    <= '0;
      lat_q        <= '0;
      found_q      <= 1'b0;
      abort_seen_q <= 1'b0;
      res_q        <= '0;
    end else begin
      state_q      <= state_d;
      hs_q         <= hs_d;
      wd_q         <= wd_d;
      nonce_q      <= nonce_d;
      count_q      <= count_d;
      issued_q     <= issued_d;
      retired_q    <= retired_d;
      lat_q        <= lat_d;
      found_q      <= found_d;
      abort_seen_q <= abort_seen_d;
      res_q        <= res_d;
    end
  end

  assign job_ready_o    = (state_q == IDLE);
  assign valid_o        = issue;
  assign newblock_o     = issue && (issued_q == '0);
  assign hashstate_o    = hs_q;
  assign words_o[2]     = {{PARTITIONBITS{1'b0}}, issue_nonce};
  assign words_o[1]     = wd_q[1];
  assign words_o[0]     = wd_q[0];
  assign result_valid_o = (state_q == DONE);
  assign result_found_o = found_q;
  assign result_nonce_o = res_q;

endmodule

// File: tb/tb_bxctreme_nonce_scheduler.sv
// Directed bench for bxctreme_nonce_scheduler with LATENCY=4.
// Vector table plus hand sequences for reset, idle victories, stability.
module tb_bxctreme_nonce_scheduler;

  localparam int PB = 1;
  localparam int NB = 32 - PB;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 job_valid_i = 1'b0;
  logic                 job_ready_o;
  logic [7:0][31:0]     job_hashstate_i = '0;
  logic [1:0][31:0]     job_words_i = '0;
  logic [NB-1:0]        job_nonce_i = '0;
  logic [NB-1:0]        job_count_i = '0;
  logic                 abort_i = 1'b0;
  logic                 valid_o;
  logic                 newblock_o;
  logic [7:0][31:0]     hashstate_o;
  logic [2:0][31:0]     words_o;
  logic                 victory_i = 1'b0;
  logic [PB-1:0]        nonce_start_i = '0;
  logic                 result_valid_o;
  logic                 result_found_o;
  logic [31:0]          result_nonce_o;
  logic                 result_ready_i = 1'b0;

  bxctreme_nonce_scheduler #(.PARTITIONBITS(PB), .LATENCY(4)) dut (
    .clk(clk), .rst(rst),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_hashstate_i(job_hashstate_i), .job_words_i(job_words_i),
    .job_nonce_i(job_nonce_i), .job_count_i(job_count_i),
    .abort_i(abort_i), .valid_o(valid_o), .newblock_o(newblock_o),
    .hashstate_o(hashstate_o), .words_o(words_o),
    .victory_i(victory_i), .nonce_start_i(nonce_start_i),
    .result_valid_o(result_valid_o), .result_found_o(result_found_o),
    .result_nonce_o(result_nonce_o), .result_ready_i(result_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] nonce;
    logic [NB-1:0] count;
    int            vic1;
    int            vic2;
    logic [PB-1:0] ps;
    int            abrt;
    int            exp_iss;
    int            exp_done;
    logic          exp_found;
    logic [31:0]   exp_res;
  } vec_t;

  vec_t vecs [7];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic accept(input logic [NB-1:0] n, input logic [NB-1:0] c);
    @(negedge clk);
    job_valid_i     = 1'b1;
    job_nonce_i     = n;
    job_count_i     = c;
    job_hashstate_i = {8{n[15:0], c[15:0]}};
    job_words_i     = {32'hCAFE0001, 32'hBEEF0000};
    #1;
    chk("job_ready", 64'(job_ready_o), 64'd1);
    @(posedge clk);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int nis = 0;
    int done = -1;
    logic [31:0] exp_w;
    accept(v.nonce, v.count);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      job_valid_i   = 1'b0;
      victory_i     = (cyc == v.vic1) || (cyc == v.vic2);
      nonce_start_i = v.ps;
      abort_i       = (cyc == v.abrt);
      #1;
      if (result_valid_o) begin
        done = cyc;
        break;
      end
      if (valid_o) begin
        exp_w = {1'b0, 31'(v.nonce + 31'(nis))};
        chk({tag, " words2"}, 64'(words_o[2]), 64'(exp_w));
        chk({tag, " newblock"}, 64'(newblock_o), 64'(nis == 0));
        chk({tag, " words0"}, 64'(words_o[0]), 64'h BEEF0000);
        nis++;
      end
      @(posedge clk);
    end
    victory_i = 1'b0;
    abort_i   = 1'b0;
    if (done < 0) begin
      errors++;
      checks++;
      $display("FAIL %s timeout: no result_valid_o", tag);
    end else begin
      chk({tag, " issues"}, 64'(nis), 64'(v.exp_iss));
      chk({tag, " done_cyc"}, 64'(done), 64'(v.exp_done));
      chk({tag, " found"}, 64'(result_found_o), 64'(v.exp_found));
      chk({tag, " res"}, 64'(result_nonce_o), 64'(v.exp_res));
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    result_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    result_ready_i = 1'b0;
    #1;
    chk("back_idle", 64'(job_ready_o), 64'd1);
  endtask

  initial begin
    vecs[0] = '{31'h10, 31'd3, 0, 0, 1'b0, 0, 3, 8, 1'b0, 32'h0};
    vecs[1] = '{31'h10, 31'd3, 6, 0, 1'b1, 0, 3, 8, 1'b1, 32'h80000011};
    vecs[2] = '{31'h10, 31'd3, 3, 0, 1'b1, 0, 3, 8, 1'b0, 32'h0};
    vecs[3] = '{31'h10, 31'd3, 5, 7, 1'b1, 0, 3, 8, 1'b1, 32'h80000010};
    vecs[4] = '{31'h7FFFFFFF, 31'd2, 0, 0, 1'b0, 0, 2, 7, 1'b0, 32'h0};
    vecs[5] = '{31'h100, 31'd10, 5, 0, 1'b0, 0, 4, 9, 1'b1, 32'h100};
    vecs[6] = '{31'h20, 31'd0, 0, 0, 1'b0, 0, 0, 1, 1'b0, 32'h0};

    #1;
    chk("rst job_ready", 64'(job_ready_o), 64'd1);
    chk("rst valid", 64'(valid_o), 64'd0);
    chk("rst result_valid", 64'(result_valid_o), 64'd0);
    chk("rst words2", 64'(words_o[2]), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Victory and abort pulsed while idle must not disturb anything.
    @(negedge clk);
    victory_i = 1'b1;
    abort_i   = 1'b1;
    @(negedge clk);
    victory_i = 1'b0;
    abort_i   = 1'b0;
    #1;
    chk("idle vic job_ready", 64'(job_ready_o), 64'd1);
    chk("idle vic result_valid", 64'(result_valid_o), 64'd0);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      release_result();
    end

    // Abort on the second RUN cycle, then hold the result unconsumed.
    run_vec('{31'h40, 31'd5, 0, 0, 1'b0, 2, 1, 6, 1'b0, 32'h0}, "abort");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      abort_i = 1'b1;
      #1;
      chk("hold result_valid", 64'(result_valid_o), 64'd1);
      chk("hold found", 64'(result_found_o), 64'd0);
      chk("hold nonce", 64'(result_nonce_o), 64'd0);
    end
    abort_i = 1'b0;
    release_result();

    // Reset in the middle of DRAIN drops the job entirely.
    accept(31'h55, 31'd3);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      job_valid_i = 1'b0;
      if (cyc == 1) begin
        #1;
        chk("drn hashstate", 64'(hashstate_o[0]), 64'h00550003);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid rst job_ready", 64'(job_ready_o), 64'd1);
    chk("mid rst valid", 64'(valid_o), 64'd0);
    chk("mid rst result_valid", 64'(result_valid_o), 64'd0);
    chk("mid rst hashstate", 64'(hashstate_o[0]), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run_vec('{31'h200, 31'd2, 0, 0, 1'b0, 0, 2, 7, 1'b0, 32'h0}, "postrst");
    release_result();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bxctreme_nonce_scheduler.md
BXCTREME_NONCE_SCHEDULER -- requirements
Module: bxctreme_nonce_scheduler

Interface
REQ-001 The block SHALL have parameter PARTITIONBITS, default 1, giving the processor-index width; NB = 32-PARTITIONBITS is the per-processor nonce width.
REQ-002 The block SHALL have parameter LATENCY, default 130, giving the fixed cycles from valid_o to the matching victory_i at the chain tail.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 job_valid_i  input  1  host offers a job.
REQ-006 job_ready_o  output  1  scheduler accepts a job.
REQ-007 job_hashstate_i  input  HashState  midstate of the job.
REQ-008 job_words_i  input  [1:0][31:0]  tail words 0 and 1.
REQ-009 job_nonce_i  input  NB  first base nonce.
REQ-010 job_count_i  input  NB  number of base nonces to issue.
REQ-011 abort_i  input  1  cancel the current job.
REQ-012 valid_o, newblock_o  output  1 each  to head of processor chain.
REQ-013 hashstate_o  output  HashState  to chain head.
REQ-014 words_o  output  [2:0][31:0]  to chain head; [2] = zero-extended base nonce.
REQ-015 victory_i  input  1  chain-tail victory.
REQ-016 nonce_start_i  input  PARTITIONBITS  chain-tail winning processor index.
REQ-017 result_valid_o, result_found_o  output  1 each  job finished / nonce found.
REQ-018 result_nonce_o  output  32  {nonce_start_i, winning base nonce}.
REQ-019 result_ready_i  input  1  host consumes the result.

Function
REQ-020 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-021 job_ready_o SHALL be 1 only in IDLE; a transfer is job_valid_i & job_ready_o; it latches all job_* inputs, clears the counters and result fields, and moves to RUN, or to DONE with result_found_o=0 when job_count_i==0.
REQ-022 In RUN, valid_o SHALL be 1 every cycle with words_o[2] = job_nonce + issued (mod 2^NB); issued increments per issue.
REQ-023 newblock_o SHALL be 1 only on the first RUN issue of a job.
REQ-024 hashstate_o and words_o[1:0] SHALL be held from the latch; valid_o=0 outside RUN.
REQ-025 RUN SHALL go to DRAIN after the issue where issued+1==count, on abort_i, or on an accepted victory, whichever comes first; no issue happens in an abort or victory cycle.
REQ-026 A latency counter SHALL start on the first issue and saturate at LATENCY; retiring is active while it equals LATENCY and retired<issued, and retired increments per retiring cycle.
REQ-027 victory_i SHALL be accepted only while retiring, result not yet found and no abort seen; it then latches result_found=1 and result_nonce = {nonce_start_i, job_nonce+retired}; outside these conditions it is ignored.
REQ-028 DRAIN SHALL move to DONE once retired==issued, so every in-flight nonce is flushed before the next job.
REQ-029 DONE SHALL hold result_valid_o=1 with stable result fields until result_ready_i, then go to IDLE; abort_i is ignored in IDLE and DONE.
REQ-030 An abort job SHALL end in DONE with result_found_o=0.
REQ-031 Counters SHALL be NB bits wide; the nonce sum wraps modulo 2^NB.

Reset
REQ-032 While rst==0, state SHALL be IDLE and all counters and outputs 0 except job_ready_o=1; on release, a job_valid_i is accepted on the first clock edge.
REQ-033 Reset mid-RUN/DRAIN SHALL drop the job and all in-flight results without a result_valid_o pulse.

Verification
REQ-034 LATENCY=4, nonce=0x10, count=3, no victory -> valid_o for 3 cycles with words_o[2]=0x10,0x11,0x12 and newblock_o on the first only; DONE found=0 at 4+3 cycles.
REQ-035 Same job, victory_i with nonce_start_i=1 on the second retiring cycle -> result_nonce_o=0x80000011, found=1, and no further issue after the victory cycle.
REQ-036 victory_i pulsed in IDLE, during the first LATENCY cycles, and again after an accepted victory -> all ignored.
REQ-037 nonce=0x7FFFFFFF, count=2 -> words_o[2]=0x7FFFFFFF, then 0x00000000.
REQ-038 abort_i on the 2nd RUN cycle -> one issue only, DRAIN until it retires, DONE found=0; result_ready_i held 0 for 5 cycles -> result outputs stable.
REQ-039 rst asserted mid-DRAIN -> all outputs at reset values next cycle; the following job runs cleanly from its own nonce.
